procyon_cdb_arbiter: RTL and testbench
======================================

// Module: procyon_cdb_arbiter
// PURPOSE
// - Shares OPTN_CDB_DEPTH common data buses among OPTN_FU_COUNT functional units.
// - Each FU result (data + ROB tag) enters a small per-FU buffer.
// - A round-robin scheduler grants up to OPTN_CDB_DEPTH buffered results per cycle onto the CDBs.
// - CDBs feed the reservation stations' tag match/wakeup and the ROB. FUs are back-pressured when their buffer is full.
// PARAMETERS
// - OPTN_DATA_WIDTH      32  result data width
// - OPTN_ROB_IDX_WIDTH   5   ROB tag width
// - OPTN_CDB_DEPTH       2   number of CDB buses; must be <= OPTN_FU_COUNT
// - OPTN_FU_COUNT        4   number of requesting functional units
// - OPTN_FU_BUF_DEPTH    2   entries per FU buffer; power of 2, >= 2
// PORTS
// - clk         in   1                      clock; all state updates on posedge
// - n_rst       in   1                      synchronous, active-low reset
// - i_flush     in   1                      pipeline flush
// - i_fu_valid  in   1    [0:FU_COUNT-1]    FU result valid
// - i_fu_data   in   DATA [0:FU_COUNT-1]    FU result data
// - i_fu_tag    in   ROB  [0:FU_COUNT-1]    FU result ROB tag
// - o_fu_stall  out  1    [0:FU_COUNT-1]    buffer full; FU must hold its result
// - o_cdb_en    out  1    [0:CDB_DEPTH-1]   CDB broadcast valid
// - o_cdb_data  out  DATA [0:CDB_DEPTH-1]   CDB data
// - o_cdb_tag   out  ROB  [0:CDB_DEPTH-1]   CDB tag
// BEHAVIOUR
// - Reset (n_rst=0 at posedge):
//   - all buffers empty; rr pointer = 0; o_cdb_en = all 0
//   - o_fu_stall = all 0 (derived from buffer count)
//   - o_cdb_data/o_cdb_tag not reset; don't-care while o_cdb_en=0
// - Enqueue: FU f enqueues when i_fu_valid[f] & ~o_fu_stall[f]. An input presented while stalled is not taken; the FU holds it.
// - o_fu_stall[f] = (count_q[f] == OPTN_FU_BUF_DEPTH).
//   - Driven from registered count only; no same-cycle dequeue bypass.
// - Buffers are FIFO per FU; head/tail pointers wrap modulo OPTN_FU_BUF_DEPTH.
//   - count width $clog2(OPTN_FU_BUF_DEPTH+1).
//   - Simultaneous enqueue+dequeue keeps count unchanged.
// - Arbitration (combinational on registered buffer state):
//   - Scan FUs in order rr_ptr, rr_ptr+1, ... mod OPTN_FU_COUNT.
//   - The first OPTN_CDB_DEPTH non-empty FUs are granted; the k-th granted FU drives CDB k.
//   - Unused CDBs get en=0.
// - Each granted FU dequeues its head entry. CDB outputs are registered and valid the cycle after grant.
// - rr_ptr update:
//   - if any grant: rr_ptr <= (index of last granted FU + 1) mod OPTN_FU_COUNT
//   - if no grant: rr_ptr unchanged
// - Latency: result enqueued at end of cycle N (empty buffer, no contention) -> o_cdb_en high in cycle N+2. Throughput is OPTN_CDB_DEPTH results/cycle.
// - Each FU's results broadcast in acceptance order. No result is dropped or duplicated except on flush.
// - A given FU appears on at most one CDB per cycle, so no two CDBs carry the same entry.
// - i_flush (sampled at posedge):
//   - all buffers emptied; o_cdb_en <= all 0; rr_ptr held
//   - inputs valid in the flush cycle are discarded
//   - results granted in the flush cycle are not broadcast
// - Reset mid-operation: same as flush, plus rr_ptr <= 0.
// STRUCTURE
// - A shared package holds typedef cdb_t {en, data, tag}, parameterised by widths, for reuse by the RS, ROB and LSU CDB ports.
//   - It also holds localparams FU_IDX_WIDTH = $clog2(OPTN_FU_COUNT) and BUF_CNT_WIDTH.
// - Sub-module procyon_cdb_buf: one per FU via generate.
//   - Per-FU FIFO with enq/deq/flush, head data/tag, empty/full, registered count.
// - The top level holds the rr pointer, the multi-grant round-robin selector (rotate-find-first, CDB_DEPTH passes) and the output registers.
// TESTING
// - Reset: hold n_rst=0 2 cycles with random inputs -> o_cdb_en all 0, o_fu_stall all 0 in the cycle after release.
// - Single result: FU0 valid, data 0xDEADBEEF, tag 5, one cycle (N) -> cycle N+2:
//   - o_cdb_en[0]=1, data 0xDEADBEEF, tag 5; o_cdb_en[1]=0
//   - cycle N+3: all en=0
// - Contention (FU_COUNT 4, CDB 2, rr=0): FUs 0-3 valid in one cycle, tags 1-4 ->
//   - next broadcast cycle: CDB0 tag1, CDB1 tag2
//   - following cycle: CDB0 tag3, CDB1 tag4
//   - rr_ptr returns to 0
// - Back-pressure: FU2 valid every cycle with tags 0,1,2,... while FUs 0,1,3 saturate ->
//   - o_fu_stall[2] asserts with 2 entries held
//   - FU2 tags appear on the CDBs strictly in order with no gaps or duplicates
// - Flush: all buffers full, i_flush=1 for one cycle ->
//   - next cycle o_cdb_en all 0 and o_fu_stall all 0
//   - no pre-flush tag ever broadcast afterwards
// - Fairness: FUs 0-3 valid every cycle for 200 cycles -> each FU's grant count within +/-1 of 100 (ignoring initial fill).

Source files
------------

// File: rtl/procyon_cdb_arbiter_pkg.sv
// Shared CDB definitions for the arbiter and for the RS, ROB and LSU CDB ports.
// The broadcast record and the index/count widths are derived from the core's
// default datapath sizes. The helper below keeps index widths legal when a
// count collapses to one.
package procyon_cdb_arbiter_pkg;

  // Default datapath sizes for the core
  localparam int CDB_DATA_WIDTH    = 32;
  localparam int CDB_TAG_WIDTH     = 5;
  localparam int CDB_DEPTH         = 2;
  localparam int CDB_FU_COUNT      = 4;
  localparam int CDB_FU_BUF_DEPTH  = 2;

  // Width of an index into n items; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FU_IDX_WIDTH  = idx_width(CDB_FU_COUNT);
  localparam int BUF_CNT_WIDTH = $clog2(CDB_FU_BUF_DEPTH + 1);

  // One common-data-bus broadcast as seen by wakeup and ROB logic
  typedef struct packed {
    logic                      en;
    logic [CDB_DATA_WIDTH-1:0] data;
    logic [CDB_TAG_WIDTH-1:0]  tag;
  } cdb_t;

endpackage

// File: rtl/procyon_cdb_buf.sv
// Per-FU result FIFO. It holds finished results until the arbiter grants the
// FU a bus. The full flag comes from the registered count only, so a result
// dequeued this cycle does not free a slot for this cycle's producer.
module procyon_cdb_buf
  import procyon_cdb_arbiter_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_FU_BUF_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic                          i_enq,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_data,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_tag,
  input  logic                          i_deq,
  output logic [OPTN_DATA_WIDTH-1:0]    o_data,
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_tag,
  output logic                          o_empty,
  output logic                          o_full
);

  localparam int PTR_W = idx_width(OPTN_FU_BUF_DEPTH);
  localparam int CNT_W = $clog2(OPTN_FU_BUF_DEPTH + 1);

  logic [OPTN_DATA_WIDTH-1:0]    data_mem [0:OPTN_FU_BUF_DEPTH-1];
  logic [OPTN_ROB_IDX_WIDTH-1:0] tag_mem  [0:OPTN_FU_BUF_DEPTH-1];
  logic [PTR_W-1:0]              head_q;
  logic [PTR_W-1:0]              tail_q;
  logic [CNT_W-1:0]              count_q;
  logic                          enq_ok;
  logic                          deq_ok;

  assign o_full  = (count_q == CNT_W'(OPTN_FU_BUF_DEPTH));
  assign o_empty = (count_q == '0);
  assign enq_ok  = i_enq & ~o_full;
  assign deq_ok  = i_deq & ~o_empty;
  assign o_data  = data_mem[head_q];
  assign o_tag   = tag_mem[head_q];

  // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO
  always_ff @(posedge clk) begin
    if (!n_rst || i_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_ok) tail_q <= tail_q + PTR_W'(1);
      if (deq_ok) head_q <= head_q + PTR_W'(1);
      case ({enq_ok, deq_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Result storage; contents are meaningless outside the head..tail window
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      data_mem[tail_q] <= i_data;
      tag_mem[tail_q]  <= i_tag;
    end
  end

endmodule

// File: rtl/procyon_cdb_arbiter.sv
// Common data bus arbiter. Each FU result is buffered per FU. Each cycle a
// round-robin scan starting at rr_ptr_q picks up to OPTN_CDB_DEPTH non-empty
// buffers. The k-th pick drives bus k one cycle later through the output
// registers. The pointer then moves just past the last FU that won.
module procyon_cdb_arbiter
  import procyon_cdb_arbiter_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_CDB_DEPTH     = 2,
  parameter int OPTN_FU_COUNT      = 4,
  parameter int OPTN_FU_BUF_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic                          i_fu_valid [0:OPTN_FU_COUNT-1],
  input  logic [OPTN_DATA_WIDTH-1:0]    i_fu_data  [0:OPTN_FU_COUNT-1],
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_fu_tag   [0:OPTN_FU_COUNT-1],
  output logic                          o_fu_stall [0:OPTN_FU_COUNT-1],
  output logic                          o_cdb_en   [0:OPTN_CDB_DEPTH-1],
  output logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data [0:OPTN_CDB_DEPTH-1],
  output logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag  [0:OPTN_CDB_DEPTH-1]
);

  localparam int IDX_W = idx_width(OPTN_FU_COUNT);

  logic                          fu_empty  [0:OPTN_FU_COUNT-1];
  logic [OPTN_DATA_WIDTH-1:0]    head_data [0:OPTN_FU_COUNT-1];
  logic [OPTN_ROB_IDX_WIDTH-1:0] head_tag  [0:OPTN_FU_COUNT-1];
  logic [OPTN_FU_COUNT-1:0]      fu_deq;

  logic [IDX_W-1:0]              rr_ptr_q;
  logic [IDX_W-1:0]              rr_next;
  logic [OPTN_FU_COUNT-1:0]      req_rem;
  logic [OPTN_CDB_DEPTH-1:0]     gnt_vld;
  logic [IDX_W-1:0]              gnt_idx [0:OPTN_CDB_DEPTH-1];
  logic [IDX_W-1:0]              scan_idx;

  logic [OPTN_CDB_DEPTH-1:0]     cdb_en_p1;
  logic [OPTN_DATA_WIDTH-1:0]    cdb_data_p1 [0:OPTN_CDB_DEPTH-1];
  logic [OPTN_ROB_IDX_WIDTH-1:0] cdb_tag_p1  [0:OPTN_CDB_DEPTH-1];

  // One result FIFO per functional unit; a full FIFO stalls its producer
  for (genvar f = 0; f < OPTN_FU_COUNT; f++) begin : g_fu_buf
    procyon_cdb_buf #(
      .OPTN_DATA_WIDTH    (OPTN_DATA_WIDTH),
      .OPTN_ROB_IDX_WIDTH (OPTN_ROB_IDX_WIDTH),
      .OPTN_FU_BUF_DEPTH  (OPTN_FU_BUF_DEPTH)
    ) u_buf (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_flush (i_flush),
      .i_enq   (i_fu_valid[f]),
      .i_data  (i_fu_data[f]),
      .i_tag   (i_fu_tag[f]),
      .i_deq   (fu_deq[f]),
      .o_data  (head_data[f]),
      .o_tag   (head_tag[f]),
      .o_empty (fu_empty[f]),
      .o_full  (o_fu_stall[f])
    );
  end

  // Multi-grant rotate-find-first: each pass takes the first remaining
  // requester at or after rr_ptr_q and removes it from later passes, so a
  // given FU can win at most one bus per cycle
  always_comb begin
    fu_deq   = '0;
    rr_next  = rr_ptr_q;
    scan_idx = '0;
    for (int f = 0; f < OPTN_FU_COUNT; f++) begin
      req_rem[f] = ~fu_empty[f];
    end
    for (int k = 0; k < OPTN_CDB_DEPTH; k++) begin
      gnt_vld[k] = 1'b0;
      gnt_idx[k] = '0;
      for (int i = 0; i < OPTN_FU_COUNT; i++) begin
        scan_idx = IDX_W'((int'(rr_ptr_q) + i) % OPTN_FU_COUNT);
        if (!gnt_vld[k] && req_rem[scan_idx]) begin
          gnt_vld[k] = 1'b1;
          gnt_idx[k] = scan_idx;
        end
      end
      if (gnt_vld[k]) begin
        req_rem[gnt_idx[k]] = 1'b0;
        fu_deq[gnt_idx[k]]  = 1'b1;
        rr_next             = IDX_W'((int'(gnt_idx[k]) + 1) % OPTN_FU_COUNT);
      end
    end
  end

  // Control state: broadcast valids and the round-robin pointer; flush drops
  // this cycle's grants but keeps the pointer where it was
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rr_ptr_q  <= '0;
      cdb_en_p1 <= '0;
    end else if (i_flush) begin
      cdb_en_p1 <= '0;
    end else begin
      cdb_en_p1 <= gnt_vld;
      rr_ptr_q  <= rr_next;
    end
  end

  // Broadcast payload; only meaningful where the matching valid is set
  always_ff @(posedge clk) begin
    for (int k = 0; k < OPTN_CDB_DEPTH; k++) begin
      cdb_data_p1[k] <= head_data[gnt_idx[k]];
      cdb_tag_p1[k]  <= head_tag[gnt_idx[k]];
    end
  end

  for (genvar k = 0; k < OPTN_CDB_DEPTH; k++) begin : g_cdb_out
    assign o_cdb_en[k]   = cdb_en_p1[k];
    assign o_cdb_data[k] = cdb_data_p1[k];
    assign o_cdb_tag[k]  = cdb_tag_p1[k];
  end

endmodule

// File: tb/tb_procyon_cdb_arbiter.sv
// Bench for procyon_cdb_arbiter: directed vectors feed an expectation queue
// that a negedge monitor drains as broadcasts appear.
module tb_procyon_cdb_arbiter;

  localparam int DW   = 32;
  localparam int TW   = 5;
  localparam int NCDB = 2;
  localparam int NFU  = 4;
  localparam int BD   = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          i_flush;
  logic          i_fu_valid [0:NFU-1];
  logic [DW-1:0] i_fu_data  [0:NFU-1];
  logic [TW-1:0] i_fu_tag   [0:NFU-1];
  logic          o_fu_stall [0:NFU-1];
  logic          o_cdb_en   [0:NCDB-1];
  logic [DW-1:0] o_cdb_data [0:NCDB-1];
  logic [TW-1:0] o_cdb_tag  [0:NCDB-1];

  always #5 clk = ~clk;

  procyon_cdb_arbiter #(
    .OPTN_DATA_WIDTH    (DW),
    .OPTN_ROB_IDX_WIDTH (TW),
    .OPTN_CDB_DEPTH     (NCDB),
    .OPTN_FU_COUNT      (NFU),
    .OPTN_FU_BUF_DEPTH  (BD)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_flush    (i_flush),
    .i_fu_valid (i_fu_valid),
    .i_fu_data  (i_fu_data),
    .i_fu_tag   (i_fu_tag),
    .o_fu_stall (o_fu_stall),
    .o_cdb_en   (o_cdb_en),
    .o_cdb_data (o_cdb_data),
    .o_cdb_tag  (o_cdb_tag)
  );

  typedef struct {
    int            cdb;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q [$];
  exp_t fu_q  [NFU][$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_on = 1'b0;
  bit   strict = 1'b1;
  bit   fair_on = 1'b0;
  bit   post_flush = 1'b0;
  bit   saw_stall2 = 1'b0;
  int   gnt_cnt [NFU];
  int   seq [NFU];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h, expected no broadcast", nm, act);
  endtask

  function automatic logic [DW-1:0] mkdata(input int f, input int s, input bit mark);
    return {mark ? 8'hF1 : 8'hC0, 12'h000, 4'(f), 8'(s)};
  endfunction

  function automatic logic [63:0] en_vec();
    return 64'({o_cdb_en[1], o_cdb_en[0]});
  endfunction

  function automatic logic [63:0] stall_vec();
    return 64'({o_fu_stall[3], o_fu_stall[2], o_fu_stall[1], o_fu_stall[0]});
  endfunction

  // Monitor: every broadcast must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    int   f;
    if (mon_on) begin
      if (!strict && o_cdb_en[0] && o_cdb_en[1])
        chk("cdb_same_fu", 64'(o_cdb_data[0][11:8] == o_cdb_data[1][11:8]), 64'd0);
      for (int k = 0; k < NCDB; k++) begin
        if (o_cdb_en[k]) begin
          if (strict) begin
            if (exp_q.size() == 0) fail_now("strict_unexpected", 64'(o_cdb_tag[k]));
            else begin
              e = exp_q.pop_front();
              chk("strict_cdb_idx", 64'(k), 64'(e.cdb));
              chk("strict_data", 64'(o_cdb_data[k]), 64'(e.data));
              chk("strict_tag", 64'(o_cdb_tag[k]), 64'(e.tag));
            end
          end else begin
            f = int'(o_cdb_data[k][11:8]);
            if (post_flush && o_cdb_data[k][31:24] == 8'hF1)
              fail_now("flush_stale_broadcast", 64'(o_cdb_data[k]));
            if (f >= NFU) fail_now("free_bad_fu", 64'(o_cdb_data[k]));
            else if (fu_q[f].size() == 0) fail_now("free_unexpected", 64'(o_cdb_data[k]));
            else begin
              e = fu_q[f].pop_front();
              chk("free_data", 64'(o_cdb_data[k]), 64'(e.data));
              chk("free_tag", 64'(o_cdb_tag[k]), 64'(e.tag));
              if (fair_on) gnt_cnt[f]++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int f = 0; f < NFU; f++) begin
      i_fu_valid[f] = 1'b0;
      i_fu_data[f]  = '0;
      i_fu_tag[f]   = '0;
    end
  endtask

  task automatic do_reset();
    mon_on  = 1'b0;
    n_rst   = 1'b0;
    i_flush = 1'b0;
    repeat (2) begin
      for (int f = 0; f < NFU; f++) begin
        i_fu_valid[f] = 1'($urandom_range(0, 1));
        i_fu_data[f]  = $urandom;
        i_fu_tag[f]   = TW'($urandom_range(0, 31));
      end
      tick();
    end
    n_rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rst_cdb_en", en_vec(), 64'd0);
    chk("rst_fu_stall", stall_vec(), 64'd0);
    mon_on = 1'b1;
  endtask

  task automatic expect_bc(input int cdb, input logic [DW-1:0] d, input int t);
    exp_t e;
    e.cdb  = cdb;
    e.data = d;
    e.tag  = TW'(t);
    exp_q.push_back(e);
  endtask

  // One-cycle burst from the FUs in mask, then the bus valids on N+1..N+4
  task automatic send(input logic [3:0] mask, input int t0, input int t1, input int t2,
                      input int t3, input logic [DW-1:0] d0, input logic [1:0] e2,
                      input logic [1:0] e3, input string nm);
    int t [NFU];
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    tick();
    for (int f = 0; f < NFU; f++) begin
      if (mask[f]) begin
        i_fu_valid[f] = 1'b1;
        i_fu_tag[f]   = TW'(t[f]);
        i_fu_data[f]  = (f == 0 && d0 != '0) ? d0 : mkdata(f, t[f], 1'b0);
      end
    end
    tick();
    idle_inputs();
    @(negedge clk); chk({nm, "_n1_en"}, en_vec(), 64'd0);
    @(negedge clk); chk({nm, "_n2_en"}, en_vec(), 64'(e2));
    @(negedge clk); chk({nm, "_n3_en"}, en_vec(), 64'(e3));
    @(negedge clk); chk({nm, "_n4_en"}, en_vec(), 64'd0);
  endtask

  // Continuous producers: an FU advances its sequence only when not stalled
  task automatic stream(input int cycles, input logic [3:0] mask, input bit mark);
    exp_t e;
    for (int c = 0; c < cycles; c++) begin
      for (int f = 0; f < NFU; f++) begin
        if (mask[f]) begin
          i_fu_valid[f] = 1'b1;
          i_fu_data[f]  = mkdata(f, seq[f], mark);
          i_fu_tag[f]   = TW'(seq[f]);
          if (o_fu_stall[f]) begin
            if (f == 2) saw_stall2 = 1'b1;
          end else begin
            e.cdb  = -1;
            e.data = i_fu_data[f];
            e.tag  = i_fu_tag[f];
            fu_q[f].push_back(e);
            seq[f]++;
          end
        end else begin
          i_fu_valid[f] = 1'b0;
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst   = 1'b0;
    i_flush = 1'b0;
    idle_inputs();
    do_reset();

    // Directed, exact bus placement and timing
    strict = 1'b1;
    expect_bc(0, 32'hDEADBEEF, 5);
    send(4'b0001, 5, 0, 0, 0, 32'hDEADBEEF, 2'b01, 2'b00, "single");

    do_reset();
    expect_bc(0, mkdata(0, 1, 1'b0), 1);
    expect_bc(1, mkdata(1, 2, 1'b0), 2);
    expect_bc(0, mkdata(2, 3, 1'b0), 3);
    expect_bc(1, mkdata(3, 4, 1'b0), 4);
    send(4'b1111, 1, 2, 3, 4, '0, 2'b11, 2'b11, "contend");

    expect_bc(0, mkdata(0, 8, 1'b0), 8);
    expect_bc(1, mkdata(3, 7, 1'b0), 7);
    send(4'b1001, 8, 0, 0, 7, '0, 2'b11, 2'b00, "rr_zero");

    expect_bc(0, mkdata(1, 11, 1'b0), 11);
    expect_bc(1, mkdata(2, 12, 1'b0), 12);
    expect_bc(0, mkdata(3, 13, 1'b0), 13);
    send(4'b1110, 0, 11, 12, 13, '0, 2'b11, 2'b01, "rotate");

    expect_bc(0, mkdata(1, 20, 1'b0), 20);
    send(4'b0010, 0, 20, 0, 0, '0, 2'b01, 2'b00, "rr_two_set");

    expect_bc(0, mkdata(2, 23, 1'b0), 23);
    expect_bc(1, mkdata(3, 24, 1'b0), 24);
    expect_bc(0, mkdata(0, 21, 1'b0), 21);
    expect_bc(1, mkdata(1, 22, 1'b0), 22);
    send(4'b1111, 21, 22, 23, 24, '0, 2'b11, 2'b11, "wrap");
    chk("strict_queue_drained", 64'(exp_q.size()), 64'd0);

    // Back-pressure: all four saturate, FU2 must stall and stay in order
    strict = 1'b0;
    for (int f = 0; f < NFU; f++) seq[f] = 0;
    saw_stall2 = 1'b0;
    tick();
    stream(30, 4'b1111, 1'b0);
    idle_inputs();
    repeat (8) @(negedge clk);
    chk("bp_stall2_seen", 64'(saw_stall2), 64'd1);
    for (int f = 0; f < NFU; f++) chk($sformatf("bp_drain_fu%0d", f), 64'(fu_q[f].size()), 64'd0);

    // Flush under load: nothing from before the flush may reach a bus
    tick();
    stream(10, 4'b1111, 1'b1);
    i_flush = 1'b1;
    for (int f = 0; f < NFU; f++) begin
      i_fu_valid[f] = 1'b1;
      i_fu_data[f]  = mkdata(f, seq[f], 1'b1);
      i_fu_tag[f]   = TW'(seq[f]);
    end
    tick();
    i_flush = 1'b0;
    idle_inputs();
    for (int f = 0; f < NFU; f++) fu_q[f].delete();
    post_flush = 1'b1;
    @(negedge clk);
    chk("flush_cdb_en", en_vec(), 64'd0);
    chk("flush_fu_stall", stall_vec(), 64'd0);
    repeat (6) @(negedge clk);
    tick();
    stream(1, 4'b0010, 1'b0);
    idle_inputs();
    repeat (5) @(negedge clk);
    chk("post_flush_fu1_seen", 64'(fu_q[1].size()), 64'd0);
    post_flush = 1'b0;

    // Fairness over a 200-cycle saturated window
    do_reset();
    for (int f = 0; f < NFU; f++) seq[f] = 0;
    tick();
    stream(10, 4'b1111, 1'b0);
    for (int f = 0; f < NFU; f++) gnt_cnt[f] = 0;
    fair_on = 1'b1;
    stream(200, 4'b1111, 1'b0);
    fair_on = 1'b0;
    idle_inputs();
    repeat (10) @(negedge clk);
    for (int f = 0; f < NFU; f++) begin
      n_cmp++;
      if (gnt_cnt[f] < 99 || gnt_cnt[f] > 101) begin
        n_err++;
        $display("FAIL fair_fu%0d: got %0d grants, expected 99..101", f, gnt_cnt[f]);
      end
      chk($sformatf("fair_drain_fu%0d", f), 64'(fu_q[f].size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
